// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit RISC CPU control path: opcode values and the
// eight fetch/execute phases walked by the sequencer.
package cpu_pkg;

  localparam int OPC_W   = 3;
  localparam int PHASE_W = 3;

  localparam logic [OPC_W-1:0] OPC_HLT = 3'd0;
  localparam logic [OPC_W-1:0] OPC_SKZ = 3'd1;
  localparam logic [OPC_W-1:0] OPC_ADD = 3'd2;
  localparam logic [OPC_W-1:0] OPC_AND = 3'd3;
  localparam logic [OPC_W-1:0] OPC_XOR = 3'd4;
  localparam logic [OPC_W-1:0] OPC_LDA = 3'd5;
  localparam logic [OPC_W-1:0] OPC_STO = 3'd6;
  localparam logic [OPC_W-1:0] OPC_JMP = 3'd7;

  typedef enum logic [PHASE_W-1:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Instructions that read an operand from memory and write the accumulator.
  function automatic logic is_aluop(input logic [OPC_W-1:0] op);
    return (op == OPC_ADD) || (op == OPC_AND) || (op == OPC_XOR) || (op == OPC_LDA);
  endfunction

endpackage

// File: rtl/ctrl_phase_counter.sv
// Wrapping phase counter for the instruction sequencer; advances by one when
// adv_i is high, otherwise holds. Asynchronous active-low reset to phase 0.
module ctrl_phase_counter
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               adv_i,
  output logic [PHASE_W-1:0] phase_o
);

  logic [PHASE_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (adv_i) phase_d = phase_q + 3'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) phase_q <= '0;
    else         phase_q <= phase_d;
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: decodes phase, opcode and zero flag into per-phase
// datapath strobes; a sticky halted flag freezes the sequence at OP_ADDR.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               halt,
  output logic               ld_pc,
  output logic               data_e,
  output logic               ld_ac,
  output logic               wr,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] phase_w;
  phase_e             ph;
  logic               halted_q, halted_d;
  logic               hlt_exec;
  logic               adv;
  logic               aluop;

  assign ph       = phase_e'(phase_w);
  assign aluop    = is_aluop(opcode);
  assign hlt_exec = (ph == OP_ADDR) && (opcode == OPC_HLT);
  assign halted_d = halted_q | (ena & hlt_exec);
  // The halting edge must not advance, so the phase is left parked at OP_ADDR.
  assign adv      = ena & ~halted_q & ~hlt_exec;

  ctrl_phase_counter u_phase (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .adv_i   (adv),
    .phase_o (phase_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (ph)
        INST_ADDR:  sel = 1'b1;
        INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        INST_LOAD,
        IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        OP_ADDR:    begin inc_pc = 1'b1; halt = (opcode == OPC_HLT); end
        OP_FETCH:   rd = aluop;
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == OPC_SKZ) && zero;
          ld_pc  = (opcode == OPC_JMP);
          data_e = (opcode == OPC_STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          inc_pc = (opcode == OPC_JMP);
          ld_pc  = (opcode == OPC_JMP);
          wr     = (opcode == OPC_STO);
          data_e = (opcode == OPC_STO);
        end
        default: ;
      endcase
    end
  end

  assign phase = phase_w;

endmodule
